vgachargen_console_ctrl: RTL and testbench

VGACHARGEN_CONSOLE_CTRL -- requirements
Module: vgachargen_console_ctrl

---
 rtl/vgachargen_console_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_vgachargen_console_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgachargen_console_ctrl.sv
// Text-console controller for a character/colour map.
// Arbitrates a host bus bridge and a console byte stream onto one shared map port,
// and runs a full-screen clear.
// Ports:
//   clk_i, arst_i          clock, asynchronous active-high reset
//   host_*_i / host_*_o    host access request, grant and read return
//   con_valid_i/data_i     console character stream, con_ready_o handshake
//   con_color_i            attribute used for console writes and clear fill
//   clear_i                clear request pulse; busy_o while anything is pending
//   cursor_o               current cursor cell
//   map_*_o / map_*_i      shared map port, read data valid one cycle after address
module vgachargen_console_ctrl #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30,
  localparam int unsigned CELLS = COLS * ROWS,
  localparam int unsigned AW = $clog2(CELLS)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [7:0]    host_ch_i,
  input  logic [7:0]    host_col_i,
  output logic          host_gnt_o,
  output logic          host_rvalid_o,
  output logic [7:0]    host_rch_o,
  output logic [7:0]    host_rcol_o,
  input  logic          con_valid_i,
  input  logic [7:0]    con_data_i,
  output logic          con_ready_o,
  input  logic [7:0]    con_color_i,
  input  logic          clear_i,
  output logic          busy_o,
  output logic [AW-1:0] cursor_o,
  output logic [AW-1:0] map_addr_o,
  output logic [7:0]    map_ch_o,
  output logic [7:0]    map_col_o,
  output logic          map_wen_o,
  input  logic [7:0]    map_ch_i,
  input  logic [7:0]    map_col_i
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] LastCell = AW'(CELLS - 1);
  localparam logic [CW-1:0] LastCol  = CW'(COLS - 1);
  localparam logic [RW-1:0] LastRow  = RW'(ROWS - 1);
  localparam logic [AW-1:0] RowStep  = AW'(COLS);

  typedef enum logic [1:0] {StIdle, StAccess, StClear} state_e;

  state_e        state_q;
  logic          clear_pend_q;
  logic          last_host_q;
  logic [AW-1:0] cursor_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [AW-1:0] map_addr_q;
  logic [7:0]    map_ch_q;
  logic [7:0]    map_col_q;
  logic          map_wen_q;
  logic          host_gnt_q;
  logic          host_rvalid_q;

  logic          clear_req;
  logic          sel_host;
  logic          sel_con;
  logic          con_xfer;
  logic          printable;
  logic [AW-1:0] cursor_d;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_d;

  // A clear arriving this cycle already blocks the console, so no byte slips in ahead of it.
  assign clear_req   = clear_pend_q | clear_i;
  // Round-robin: on a tie the requester granted last loses.
  assign sel_host    = host_req_i & (~con_valid_i | ~last_host_q);
  assign sel_con     = con_valid_i & ~sel_host;
  assign con_ready_o = (state_q == StIdle) & ~clear_req & sel_con;
  assign con_xfer    = con_valid_i & con_ready_o;

  // Cursor next-state for the byte on con_data_i; row/col tracked alongside to avoid a divider.
  always_comb begin
    cursor_d  = cursor_q;
    col_d     = col_q;
    row_d     = row_q;
    printable = 1'b0;
    case (con_data_i)
      8'h0A: begin
        col_d = '0;
        if (row_q == LastRow) begin
          row_d    = '0;
          cursor_d = '0;
        end else begin
          row_d    = row_q + RW'(1);
          cursor_d = cursor_q - AW'(col_q) + RowStep;
        end
      end
      8'h0D: begin
        col_d    = '0;
        cursor_d = cursor_q - AW'(col_q);
      end
      8'h08: begin
        if (cursor_q != '0) begin
          cursor_d = cursor_q - AW'(1);
          if (col_q == '0) begin
            col_d = LastCol;
            row_d = row_q - RW'(1);
          end else begin
            col_d = col_q - CW'(1);
          end
        end
      end
      default: begin
        printable = 1'b1;
        if (cursor_q == LastCell) begin
          cursor_d = '0;
          col_d    = '0;
          row_d    = '0;
        end else begin
          cursor_d = cursor_q + AW'(1);
          if (col_q == LastCol) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q       <= StIdle;
      clear_pend_q  <= 1'b0;
      last_host_q   <= 1'b0;
      cursor_q      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      map_addr_q    <= '0;
      map_ch_q      <= '0;
      map_col_q     <= '0;
      map_wen_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_gnt_q    <= 1'b0;
      map_wen_q     <= 1'b0;
      // Read data returns the cycle after a host read's ACCESS cycle.
      host_rvalid_q <= (state_q == StAccess) & host_gnt_q & ~map_wen_q;
      if (clear_i && state_q != StClear) clear_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (clear_req) begin
            state_q    <= StClear;
            map_addr_q <= '0;
            map_ch_q   <= 8'h20;
            map_col_q  <= con_color_i;
            map_wen_q  <= 1'b1;
          end else if (sel_host) begin
            state_q     <= StAccess;
            host_gnt_q  <= 1'b1;
            last_host_q <= 1'b1;
            map_addr_q  <= host_addr_i;
            map_ch_q    <= host_ch_i;
            map_col_q   <= host_col_i;
            map_wen_q   <= host_we_i;
          end else if (con_xfer) begin
            state_q     <= StAccess;
            last_host_q <= 1'b0;
            map_addr_q  <= cursor_q;
            map_ch_q    <= con_data_i;
            map_col_q   <= con_color_i;
            map_wen_q   <= printable;
            cursor_q    <= cursor_d;
            col_q       <= col_d;
            row_q       <= row_d;
          end
        end
        StAccess: state_q <= StIdle;
        StClear: begin
          if (map_addr_q == LastCell) begin
            state_q      <= StIdle;
            clear_pend_q <= 1'b0;
            cursor_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
          end else begin
            map_addr_q <= map_addr_q + AW'(1);
            map_col_q  <= con_color_i;
            map_wen_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = (state_q != StIdle) | clear_req;
  assign cursor_o      = cursor_q;
  assign map_addr_o    = map_addr_q;
  assign map_ch_o      = map_ch_q;
  assign map_col_o     = map_col_q;
  assign map_wen_o     = map_wen_q;
  assign host_gnt_o    = host_gnt_q;
  assign host_rvalid_o = host_rvalid_q;
  assign host_rch_o    = host_rvalid_q ? map_ch_i : 8'h00;
  assign host_rcol_o   = host_rvalid_q ? map_col_i : 8'h00;

endmodule

// File: tb/tb_vgachargen_console_ctrl.sv
module tb_vgachargen_console_ctrl;

  localparam int unsigned AW = 12;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b1;
  logic          host_req_i = 1'b0;
  logic          host_we_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic [7:0]    host_ch_i = '0;
  logic [7:0]    host_col_i = '0;
  logic          host_gnt_o;
  logic          host_rvalid_o;
  logic [7:0]    host_rch_o;
  logic [7:0]    host_rcol_o;
  logic          con_valid_i = 1'b0;
  logic [7:0]    con_data_i = '0;
  logic          con_ready_o;
  logic [7:0]    con_color_i = '0;
  logic          clear_i = 1'b0;
  logic          busy_o;
  logic [AW-1:0] cursor_o;
  logic [AW-1:0] map_addr_o;
  logic [7:0]    map_ch_o;
  logic [7:0]    map_col_o;
  logic          map_wen_o;
  logic [7:0]    map_ch_i = '0;
  logic [7:0]    map_col_i = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic          o_wen;
  logic [AW-1:0] o_addr;
  logic [7:0]    o_ch;
  logic [7:0]    o_col;

  vgachargen_console_ctrl dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .host_req_i    (host_req_i),
    .host_we_i     (host_we_i),
    .host_addr_i   (host_addr_i),
    .host_ch_i     (host_ch_i),
    .host_col_i    (host_col_i),
    .host_gnt_o    (host_gnt_o),
    .host_rvalid_o (host_rvalid_o),
    .host_rch_o    (host_rch_o),
    .host_rcol_o   (host_rcol_o),
    .con_valid_i   (con_valid_i),
    .con_data_i    (con_data_i),
    .con_ready_o   (con_ready_o),
    .con_color_i   (con_color_i),
    .clear_i       (clear_i),
    .busy_o        (busy_o),
    .cursor_o      (cursor_o),
    .map_addr_o    (map_addr_o),
    .map_ch_o      (map_ch_o),
    .map_col_o     (map_col_o),
    .map_wen_o     (map_wen_o),
    .map_ch_i      (map_ch_i),
    .map_col_i     (map_col_i)
  );

  always #5 clk_i = ~clk_i;

  // Map stand-in: data is a fixed function of the address, one cycle late.
  always @(posedge clk_i) begin
    map_ch_i  <= map_addr_o[7:0] + 8'h10;
    map_col_i <= ~map_addr_o[7:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one console byte; called and returns at a negedge in IDLE.
  task automatic con_put(input logic [7:0] d, input logic [7:0] c);
    int g;
    g = 0;
    con_valid_i = 1'b1;
    con_data_i  = d;
    con_color_i = c;
    #1;
    while (!con_ready_o && g < 20) begin
      @(negedge clk_i);
      #1;
      g++;
    end
    if (!con_ready_o) check_eq("con_ready_tmo", 32'(con_ready_o), 32'd1);
    @(negedge clk_i);
    o_wen  = map_wen_o;
    o_addr = map_addr_o;
    o_ch   = map_ch_o;
    o_col  = map_col_o;
    con_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n_wr;
    int n_bad;
    int exp_a;

    // Reset state
    repeat (2) @(negedge clk_i);
    check_eq("rst_wen", 32'(map_wen_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_cursor", 32'(cursor_o), 32'd0);
    check_eq("rst_gnt", 32'(host_gnt_o), 32'd0);
    check_eq("rst_rvalid", 32'(host_rvalid_o), 32'd0);
    arst_i = 1'b0;

    // 'A','B' with colour 0x1F, ready every second cycle
    con_valid_i = 1'b1; con_data_i = 8'h41; con_color_i = 8'h1F;
    #1;
    check_eq("ab_rdy0", 32'(con_ready_o), 32'd1);
    @(negedge clk_i);
    check_eq("ab_rdy1", 32'(con_ready_o), 32'd0);
    check_eq("a_wen", 32'(map_wen_o), 32'd1);
    check_eq("a_addr", 32'(map_addr_o), 32'd0);
    check_eq("a_ch", 32'(map_ch_o), 32'h41);
    check_eq("a_col", 32'(map_col_o), 32'h1F);
    con_data_i = 8'h42;
    @(negedge clk_i);
    check_eq("ab_rdy2", 32'(con_ready_o), 32'd1);
    @(negedge clk_i);
    check_eq("b_wen", 32'(map_wen_o), 32'd1);
    check_eq("b_addr", 32'(map_addr_o), 32'd1);
    check_eq("b_ch", 32'(map_ch_o), 32'h42);
    con_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("ab_cursor", 32'(cursor_o), 32'd2);

    // LF from 2 -> 80, LF -> 160, five chars -> 165, CR -> 160
    con_put(8'h0A, 8'h07);
    check_eq("lf_cursor80", 32'(cursor_o), 32'd80);
    con_put(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) con_put(8'h61, 8'h07);
    check_eq("cursor165", 32'(cursor_o), 32'd165);
    con_put(8'h0D, 8'h07);
    check_eq("cr_wen", 32'(o_wen), 32'd0);
    check_eq("cr_cursor", 32'(cursor_o), 32'd160);

    // 27 LF -> 2320, 30 chars -> 2350, LF on last row -> 0
    for (int i = 0; i < 27; i++) con_put(8'h0A, 8'h07);
    for (int i = 0; i < 30; i++) con_put(8'h62, 8'h07);
    check_eq("cursor2350", 32'(cursor_o), 32'd2350);
    con_put(8'h0A, 8'h07);
    check_eq("lf_wrap", 32'(cursor_o), 32'd0);
    check_eq("lf_wen", 32'(o_wen), 32'd0);

    // BS at 0 stays 0
    con_put(8'h08, 8'h07);
    check_eq("bs0_wen", 32'(o_wen), 32'd0);
    check_eq("bs0_cursor", 32'(cursor_o), 32'd0);

    // 29 LF -> 2320, 79 chars -> 2399, 'Z' at 2399 wraps to 0
    for (int i = 0; i < 29; i++) con_put(8'h0A, 8'h07);
    for (int i = 0; i < 79; i++) con_put(8'h63, 8'h07);
    check_eq("cursor2399", 32'(cursor_o), 32'd2399);
    con_put(8'h5A, 8'h4E);
    check_eq("z_wen", 32'(o_wen), 32'd1);
    check_eq("z_addr", 32'(o_addr), 32'd2399);
    check_eq("z_ch", 32'(o_ch), 32'h5A);
    check_eq("z_col", 32'(o_col), 32'h4E);
    check_eq("z_cursor", 32'(cursor_o), 32'd0);

    // 'Q' -> 1, BS -> 0
    con_put(8'h51, 8'h07);
    check_eq("q_cursor", 32'(cursor_o), 32'd1);
    con_put(8'h08, 8'h07);
    check_eq("bs_cursor", 32'(cursor_o), 32'd0);

    // Host read of addr 5 competing with console 'x'; host wins first tie
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 12'd5;
    host_ch_i = 8'hEE; host_col_i = 8'hDD;
    con_valid_i = 1'b1; con_data_i = 8'h78; con_color_i = 8'h07;
    #1;
    check_eq("arb_rdy_n0", 32'(con_ready_o), 32'd0);
    @(negedge clk_i);
    check_eq("arb_gnt_n1", 32'(host_gnt_o), 32'd1);
    check_eq("arb_wen_n1", 32'(map_wen_o), 32'd0);
    check_eq("arb_addr_n1", 32'(map_addr_o), 32'd5);
    @(negedge clk_i);
    check_eq("arb_rvalid_n2", 32'(host_rvalid_o), 32'd1);
    check_eq("arb_rch_n2", 32'(host_rch_o), 32'h15);
    check_eq("arb_rcol_n2", 32'(host_rcol_o), 32'hFA);
    check_eq("arb_gnt_n2", 32'(host_gnt_o), 32'd0);
    check_eq("arb_rdy_n2", 32'(con_ready_o), 32'd1);
    @(negedge clk_i);
    check_eq("arb_gnt_n3", 32'(host_gnt_o), 32'd0);
    check_eq("arb_wen_n3", 32'(map_wen_o), 32'd1);
    check_eq("arb_addr_n3", 32'(map_addr_o), 32'd0);
    check_eq("arb_ch_n3", 32'(map_ch_o), 32'h78);
    @(negedge clk_i);
    check_eq("arb_rdy_n4", 32'(con_ready_o), 32'd0);
    check_eq("arb_rvalid_n4", 32'(host_rvalid_o), 32'd0);
    @(negedge clk_i);
    check_eq("arb_gnt_n5", 32'(host_gnt_o), 32'd1);
    host_req_i = 1'b0;
    con_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("arb_cursor", 32'(cursor_o), 32'd1);
    @(negedge clk_i);

    // Clear with a console byte offered in the same cycle
    clear_i = 1'b1;
    con_valid_i = 1'b1; con_data_i = 8'h43; con_color_i = 8'h2E;
    #1;
    check_eq("clr_rdy0", 32'(con_ready_o), 32'd0);
    check_eq("clr_busy0", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    clear_i = 1'b0;
    exp_a = 0; n_wr = 0; n_bad = 0; g = 0;
    while (busy_o && g < 3000) begin
      if (!map_wen_o || map_addr_o != AW'(exp_a) || map_ch_o != 8'h20 ||
          map_col_o != 8'h2E || con_ready_o || host_gnt_o) n_bad++;
      if (map_wen_o) begin
        n_wr++;
        exp_a++;
      end
      @(negedge clk_i);
      g++;
    end
    check_eq("clr_writes", 32'(n_wr), 32'd2400);
    check_eq("clr_bad", 32'(n_bad), 32'd0);
    check_eq("clr_done_wen", 32'(map_wen_o), 32'd0);
    check_eq("clr_done_cursor", 32'(cursor_o), 32'd0);
    check_eq("clr_done_rdy", 32'(con_ready_o), 32'd1);
    @(negedge clk_i);
    check_eq("clr_c_wen", 32'(map_wen_o), 32'd1);
    check_eq("clr_c_addr", 32'(map_addr_o), 32'd0);
    check_eq("clr_c_ch", 32'(map_ch_o), 32'h43);
    con_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("clr_c_cursor", 32'(cursor_o), 32'd1);

    // Reset in the middle of a clear at address 1000
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    g = 0;
    while (!(map_wen_o && map_addr_o == 12'd1000) && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    check_eq("rst_mid_reach", 32'(map_addr_o), 32'd1000);
    arst_i = 1'b1;
    #1;
    check_eq("rst_mid_wen", 32'(map_wen_o), 32'd0);
    check_eq("rst_mid_busy", 32'(busy_o), 32'd0);
    check_eq("rst_mid_cursor", 32'(cursor_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    arst_i = 1'b0;
    #1;
    check_eq("post_rst_busy", 32'(busy_o), 32'd0);
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 12'd77;
    host_ch_i = 8'h55; host_col_i = 8'h66;
    @(negedge clk_i);
    check_eq("hw_gnt", 32'(host_gnt_o), 32'd1);
    check_eq("hw_wen", 32'(map_wen_o), 32'd1);
    check_eq("hw_addr", 32'(map_addr_o), 32'd77);
    check_eq("hw_ch", 32'(map_ch_o), 32'h55);
    check_eq("hw_col", 32'(map_col_o), 32'h66);
    host_req_i = 1'b0;
    @(negedge clk_i);
    check_eq("hw_gnt_off", 32'(host_gnt_o), 32'd0);
    check_eq("hw_wen_off", 32'(map_wen_o), 32'd0);
    check_eq("hw_rvalid", 32'(host_rvalid_o), 32'd0);
    check_eq("hw_busy", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
